vga_stream_disp: RTL and testbench

//  Parametrised VGA timing generator plus pixel unpacker for the DDR-to-VGA display path.
//  - Pulls packed WORD_W-bit frame-buffer words from a first-word-fall-through (FWFT) read FIFO.
//  - Unpacks each word into PPW = WORD_W/PIX_W pixels, MSB pixel first.
//  - Drives hsync/vsync/de/RGB with every output aligned.
//  - Reports FIFO starvation instead of displaying stale data.

---
 rtl/vga_stream_disp.sv | 144 ++++++++++++++
 tb/tb_vga_stream_disp.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vga_stream_disp.sv
// VGA timing generator with FWFT-FIFO pixel unpacker and sticky underflow detection.
// Optional colour-bar test pattern enabled by defining VGA_TESTPAT_EN.
module vga_stream_disp #(
  parameter int unsigned H_TOTAL    = 1664,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_DE_START = 320,
  parameter int unsigned H_DE_END   = 1600,
  parameter int unsigned V_TOTAL    = 790,
  parameter int unsigned V_SYNC     = 7,
  parameter int unsigned V_DE_START = 43,
  parameter int unsigned V_DE_END   = 763,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned R_W        = 5,
  parameter int unsigned G_W        = 6,
  parameter int unsigned B_W        = 5
) (
  input  logic              vga_clk,
  input  logic              vga_rst,
  input  logic [WORD_W-1:0] rd_data,
  input  logic              rd_empty,
  output logic              rd_en,
  input  logic              ufl_clr,
`ifdef VGA_TESTPAT_EN
  input  logic              test_en,
`endif
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_de,
  output logic [R_W-1:0]    vga_r,
  output logic [G_W-1:0]    vga_g,
  output logic [B_W-1:0]    vga_b,
  output logic              frame_start,
  output logic              underflow
);

  localparam int unsigned PixW = R_W + G_W + B_W;
  localparam int unsigned Ppw  = WORD_W / PixW;
  localparam int unsigned HW   = $clog2(H_TOTAL);
  localparam int unsigned VW   = $clog2(V_TOTAL);
  localparam int unsigned PW   = (Ppw > 1) ? $clog2(Ppw) : 1;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [PW-1:0]     pix_idx_q, pix_idx_d;
  logic [WORD_W-1:0] word_reg_q, word_reg_d, word_shift;
  logic              starve_q, starve_d;
  logic              underflow_q, underflow_d;
  logic              hsync_q, vsync_q, de_q, frame_start_q;
  logic [PixW-1:0]   rgb_q, pix;
  logic              h_wrap, de0, fetch, test_act;

`ifdef VGA_TESTPAT_EN
  localparam int unsigned BarW = (H_DE_END - H_DE_START) / 8;
  logic        test_q;
  logic [31:0] h_off;
  logic [2:0]  bar;
  assign test_act = test_q;
  assign h_off    = 32'(h_q) - H_DE_START;
  assign bar      = 3'(h_off / BarW);
`else
  assign test_act = 1'b0;
`endif

  always_comb begin
    h_wrap = (32'(h_q) == H_TOTAL - 1);
    de0    = (32'(h_q) >= H_DE_START) && (32'(h_q) < H_DE_END) &&
             (32'(v_q) >= V_DE_START) && (32'(v_q) < V_DE_END);
    fetch  = de0 && (pix_idx_q == '0);
    rd_en  = fetch && !rd_empty && !vga_rst && !test_act;

    h_d = h_wrap ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_wrap) v_d = (32'(v_q) == V_TOTAL - 1) ? '0 : v_q + 1'b1;

    pix_idx_d = '0;
    if (de0) pix_idx_d = (32'(pix_idx_q) == Ppw - 1) ? '0 : pix_idx_q + 1'b1;

    word_shift = word_reg_q << (32'(pix_idx_q) * PixW);
    word_reg_d = rd_en ? rd_data : word_reg_q;
    starve_d   = (fetch && !test_act) ? rd_empty : starve_q;

    // Starved slots show black for the whole word rather than stale data.
    pix = '0;
    if (fetch) begin
      if (!rd_empty) pix = rd_data[WORD_W-1 -: PixW];
    end else if (!starve_q) begin
      pix = word_shift[WORD_W-1 -: PixW];
    end
`ifdef VGA_TESTPAT_EN
    if (test_act) pix = {{B_W{~bar[0]}}, {G_W{~bar[2]}}, {R_W{~bar[1]}}};
`endif

    underflow_d = underflow_q;
    if (ufl_clr) underflow_d = 1'b0;
    if (fetch && rd_empty && !test_act) underflow_d = 1'b1;
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      h_q           <= '0;
      v_q           <= '0;
      pix_idx_q     <= '0;
      word_reg_q    <= '0;
      starve_q      <= 1'b0;
      underflow_q   <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
`ifdef VGA_TESTPAT_EN
      test_q        <= 1'b0;
`endif
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      pix_idx_q     <= pix_idx_d;
      word_reg_q    <= word_reg_d;
      starve_q      <= starve_d;
      underflow_q   <= underflow_d;
      hsync_q       <= (32'(h_q) < H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= (32'(v_q) < V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      de_q          <= de0;
      rgb_q         <= de0 ? pix : '0;
      frame_start_q <= (h_q == '0) && (v_q == '0);
`ifdef VGA_TESTPAT_EN
      // Mode only changes at the frame boundary so a frame is never mixed.
      if ((h_q == '0) && (v_q == '0)) test_q <= test_en;
`endif
    end
  end

  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_de      = de_q;
  assign vga_r       = rgb_q[R_W-1:0];
  assign vga_g       = rgb_q[R_W +: G_W];
  assign vga_b       = rgb_q[PixW-1 -: B_W];
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_stream_disp.sv
// Randomized scoreboard bench for vga_stream_disp in a small 16x6 timing configuration.
module tb_vga_stream_disp;

  localparam int NCyc   = 3000;
  localparam int RstCyc = 2 + 2 * 96 + 3 * 16 + 6;  // mid-line 3 of the third frame

  logic        clk = 1'b0;
  logic        vga_rst = 1'b1;
  logic [31:0] rd_data = '0;
  logic        rd_empty = 1'b1;
  logic        rd_en;
  logic        ufl_clr = 1'b0;
  logic        vga_hsync, vga_vsync, vga_de, frame_start, underflow;
  logic [4:0]  vga_r, vga_b;
  logic [5:0]  vga_g;

  always #5 clk = ~clk;

  vga_stream_disp #(
    .H_TOTAL(16), .H_SYNC(2), .H_DE_START(4), .H_DE_END(12),
    .V_TOTAL(6), .V_SYNC(1), .V_DE_START(2), .V_DE_END(4),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .WORD_W(32), .R_W(5), .G_W(6), .B_W(5)
  ) dut (
    .vga_clk(clk), .vga_rst(vga_rst), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_en(rd_en), .ufl_clr(ufl_clr),
`ifdef VGA_TESTPAT_EN
    .test_en(1'b0),
`endif
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .underflow(underflow)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
    logic        fs;
    logic        uf;
  } regs_t;

  typedef struct {
    logic  chk;
    regs_t r;
    logic  rden;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] fifo[$];
  int          checks = 0;
  int          passes = 0;

  // Reference model state: position as elapsed cycles since the last reset.
  int          t = 0;
  bit          uf_m = 1'b0;
  bit          starve_m = 1'b0;
  logic [31:0] word_m = '0;
  regs_t       cur_r = '0;
  bit          cur_valid = 1'b0;

  task automatic model_step(input bit rst, input bit clr, output regs_t nx, output bit pop);
    int          h, v;
    bit          active, set;
    logic [15:0] px;
    pop = 1'b0;
    if (rst) begin
      nx   = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 16'h0, fs: 1'b0, uf: 1'b0};
      t    = 0;
      uf_m = 1'b0;
    end else begin
      h      = t % 16;
      v      = (t / 16) % 6;
      active = (h >= 4) && (h < 12) && (v >= 2) && (v < 4);
      set    = 1'b0;
      px     = 16'h0;
      if (active && ((h - 4) % 2 == 0)) begin
        if (fifo.size() > 0) begin
          pop      = 1'b1;
          word_m   = fifo.pop_front();
          starve_m = 1'b0;
          px       = word_m[31:16];
        end else begin
          starve_m = 1'b1;
          set      = 1'b1;
        end
      end else if (active) begin
        px = starve_m ? 16'h0 : word_m[15:0];
      end
      uf_m = set ? 1'b1 : (clr ? 1'b0 : uf_m);
      nx   = '{hs: (h >= 2), vs: (v >= 1), de: active, rgb: (active ? px : 16'h0),
               fs: (t % 96 == 0), uf: uf_m};
      t++;
    end
  endtask

  initial begin : driver
    regs_t nx;
    bit    pop, rst, clr;
    for (int cyc = 0; cyc < NCyc; cyc++) begin
      @(posedge clk);
      #1;
      rst = (cyc < 2) || (cyc == RstCyc) || (cyc > 1000 && $urandom_range(0, 599) == 0);
      if (cyc < 200) begin
        while (fifo.size() < 3) fifo.push_back(32'hF800_07E0);
      end else if (cyc < 400) begin
        while (fifo.size() < 3) fifo.push_back($urandom);
      end else if (cyc < 2000) begin
        if ($urandom_range(0, 2) == 0 && fifo.size() < 4) fifo.push_back($urandom);
      end else begin
        if ($urandom_range(0, 2) != 0 && fifo.size() < 4) fifo.push_back($urandom);
      end
      clr      = (cyc >= 600 && cyc < 1300) ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 9) == 0);
      vga_rst  = rst;
      ufl_clr  = clr;
      rd_empty = (fifo.size() == 0);
      rd_data  = (fifo.size() == 0) ? $urandom : fifo[0];
      model_step(rst, clr, nx, pop);
      expq.push_back('{chk: cur_valid, r: cur_r, rden: pop});
      cur_r     = nx;
      cur_valid = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : monitor
    exp_t  e;
    regs_t act;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        act = '{hs: vga_hsync, vs: vga_vsync, de: vga_de, rgb: {vga_b, vga_g, vga_r},
                fs: frame_start, uf: underflow};
        checks++;
        if (rd_en === e.rden) passes++;
        else $display("FAIL rd_en t=%0t actual=%b required=%b", $time, rd_en, e.rden);
        if (e.chk) begin
          checks++;
          if (act === e.r) passes++;
          else $display("FAIL outputs t=%0t actual hs=%b vs=%b de=%b rgb=%h fs=%b uf=%b required hs=%b vs=%b de=%b rgb=%h fs=%b uf=%b",
                        $time, act.hs, act.vs, act.de, act.rgb, act.fs, act.uf,
                        e.r.hs, e.r.vs, e.r.de, e.r.rgb, e.r.fs, e.r.uf);
        end
      end
    end
  end

endmodule
